seq_pattern_det: RTL and testbench
==================================

SEQ_PATTERN_DET -- requirements
Module: seq_pattern_det

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8, giving the maximum pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the match-counter width.
REQ-003 The block SHALL have parameter RST_PAT, default 8'b0000_1011, giving the pattern loaded at reset, LSB-aligned.
REQ-004 The block SHALL have parameter RST_LEN, default 4, giving the pattern length loaded at reset.
REQ-005 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-006 Port reset  input  1  reset, asynchronous, active-high.
REQ-007 Port x  input  1  serial data bit.
REQ-008 Port in_valid  input  1  qualifies x; bit sampled only when high.
REQ-009 Port pat_load  input  1  load pat/pat_len and restart detection.
REQ-010 Port pat  input  MAX_LEN  new pattern; pat[len-1] = first bit expected, pat[0] = last.
REQ-011 Port pat_len  input  $clog2(MAX_LEN+1)  new pattern length.
REQ-012 Port overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
REQ-013 Port cnt_clr  input  1  synchronous clear of match_cnt.
REQ-014 Port z  output  1  registered one-cycle match pulse.
REQ-015 Port match_cnt  output  CNT_W  saturating count of matches.
REQ-016 Port armed  output  1  high when a nonzero pattern length is active.

Function
REQ-017 The block SHALL keep a history shift register (MAX_LEN bits) and a fill counter (0..MAX_LEN) of valid bits received since the last restart.
REQ-018 On each cycle with in_valid=1 and pat_load=0, the block SHALL shift x into history bit 0 and increment fill, saturating at MAX_LEN.
REQ-019 A match SHALL occur when the active length L>0, fill (after the update) >= L, and history[L-1:0] == active pattern[L-1:0].
REQ-020 z SHALL be high exactly in the cycle after the clock edge that sampled the completing bit, with latency 1 clock; otherwise z SHALL be 0.
REQ-021 In overlap=1, history and fill SHALL be retained after a match (1011 on stream 1011011 gives 2 matches).
REQ-022 In overlap=0, fill SHALL be cleared to 0 on the matching edge, so the next match needs L fresh bits (stream 1011011 gives 1 match).
REQ-023 On a cycle with in_valid=0, history/fill SHALL hold and z SHALL be 0 in the next cycle.
REQ-024 On pat_load=1, the block SHALL latch pat and pat_len, clear history and fill, discard any same-cycle x, and produce no match.
REQ-025 A pat_len greater than MAX_LEN SHALL be clamped to MAX_LEN.
REQ-026 pat_len=0 SHALL disable detection (armed=0, z stays 0) until a nonzero load.
REQ-027 Pattern bits above the active length SHALL be ignored in the comparison.
REQ-028 match_cnt SHALL increment by 1 per match and saturate at 2^CNT_W-1.
REQ-029 If cnt_clr and a match occur on the same edge, match_cnt SHALL become 1.
REQ-030 cnt_clr alone SHALL set match_cnt to 0.
REQ-031 overlap SHALL be sampled per edge, and a change SHALL take effect from the next match decision.

Reset
REQ-032 On reset assertion, the block SHALL immediately (asynchronously) clear history, fill, z and match_cnt, load pattern RST_PAT and length RST_LEN, and set armed=1 if RST_LEN>0.
REQ-033 A reset asserted mid-sequence SHALL discard partial matches; detection restarts from fill=0 on the first valid bit after deassertion.

Verification
REQ-034 Defaults, overlap=1, in_valid=1, x=1,0,1,1,0,1,1 -> z pulses the cycle after bit 4 and after bit 7; match_cnt=2.
REQ-035 Same stream with overlap=0 -> single z pulse after bit 4; match_cnt=1.
REQ-036 Load pat=8'b0000_0110, pat_len=3, then x=1,1,0 with in_valid toggling 1,0,1,0,1 -> z one cycle after third valid bit only; no pulse on invalid cycles.
REQ-037 Load pat_len=0, then stream 1011 repeatedly -> armed=0, z never asserts; then load pat_len=12 with MAX_LEN=8 -> effective length 8.
REQ-038 CNT_W=2, 5 matches -> match_cnt saturates at 3; cnt_clr coincident with 6th match -> match_cnt=1.
REQ-039 Apply x=1,0,1, assert reset for 1 cycle, then apply x=1 -> no z; then 0,1,1 -> no z until the full 1011 is seen post-reset.

Source files
------------

// File: rtl/seq_pattern_det.sv
// Serial bit-pattern detector with a runtime-loadable pattern and a saturating match counter.
// Ports: clk, reset (async, active-high), x/in_valid (serial data), pat_load/pat/pat_len (new pattern),
//        overlap, cnt_clr, z (one-cycle match pulse), match_cnt, armed.
module seq_pattern_det #(
   parameter int                 MAX_LEN = 8,
   parameter int                 CNT_W   = 8,
   parameter logic [MAX_LEN-1:0] RST_PAT = 8'b0000_1011,
   parameter int                 RST_LEN = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         x,
   input  logic                         in_valid,
   input  logic                         pat_load,
   input  logic [MAX_LEN-1:0]           pat,
   input  logic [$clog2(MAX_LEN+1)-1:0] pat_len,
   input  logic                         overlap,
   input  logic                         cnt_clr,
   output logic                         z,
   output logic [CNT_W-1:0]             match_cnt,
   output logic                         armed
);

   localparam int               LW   = $clog2(MAX_LEN+1);
   localparam logic [LW-1:0]    MAXL = LW'(MAX_LEN);
   localparam logic [LW-1:0]    RSTL = (RST_LEN > MAX_LEN) ? MAXL : LW'(RST_LEN);
   localparam logic [CNT_W-1:0] CMAX = '1;

   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LW-1:0]      fill_q, fill_d;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LW-1:0]      len_q, len_d;
   logic               z_q, z_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [MAX_LEN-1:0] hist_sh;
   logic [MAX_LEN-1:0] mask;
   logic [LW-1:0]      fill_inc;
   logic               sample;
   logic               match;

   // Match evaluation uses the history/fill as they will be after this edge.
   always_comb begin
      hist_sh  = {hist_q[MAX_LEN-2:0], x};
      fill_inc = (fill_q == MAXL) ? fill_q : fill_q + LW'(1);
      mask     = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(len_q));
      end
      sample = in_valid & ~pat_load;
      match  = sample && (len_q != '0) && (fill_inc >= len_q)
               && (((hist_sh ^ pat_q) & mask) == '0);
   end

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      pat_d  = pat_q;
      len_d  = len_q;
      z_d    = match;
      cnt_d  = cnt_q;
      if (pat_load) begin
         pat_d  = pat;
         len_d  = (pat_len > MAXL) ? MAXL : pat_len;
         hist_d = '0;
         fill_d = '0;
      end else if (in_valid) begin
         hist_d = hist_sh;
         // Non-overlapping mode needs a full fresh pattern after each hit.
         fill_d = (match && !overlap) ? '0 : fill_inc;
      end
      if (cnt_clr) begin
         cnt_d = match ? CNT_W'(1) : '0;
      end else if (match && cnt_q != CMAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
         pat_q  <= RST_PAT;
         len_q  <= RSTL;
         z_q    <= 1'b0;
         cnt_q  <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         pat_q  <= pat_d;
         len_q  <= len_d;
         z_q    <= z_d;
         cnt_q  <= cnt_d;
      end
   end

   assign z         = z_q;
   assign match_cnt = cnt_q;
   assign armed     = (len_q != '0);

endmodule

// File: tb/tb_seq_pattern_det.sv
// Directed bench for seq_pattern_det with a bit-queue reference model and result scoreboard.
// Two instances share stimulus: default parameters and CNT_W=2 for counter saturation.
module tb_seq_pattern_det;

   logic       clk = 1'b0;
   logic       reset, x, in_valid, pat_load, overlap, cnt_clr;
   logic [7:0] pat;
   logic [3:0] pat_len;
   logic       z, z2, armed, armed2;
   logic [7:0] cnt;
   logic [1:0] cnt2;

   always #5 clk = ~clk;

   seq_pattern_det u_dut (
      .clk(clk), .reset(reset), .x(x), .in_valid(in_valid),
      .pat_load(pat_load), .pat(pat), .pat_len(pat_len),
      .overlap(overlap), .cnt_clr(cnt_clr),
      .z(z), .match_cnt(cnt), .armed(armed)
   );

   seq_pattern_det #(.CNT_W(2)) u_dut2 (
      .clk(clk), .reset(reset), .x(x), .in_valid(in_valid),
      .pat_load(pat_load), .pat(pat), .pat_len(pat_len),
      .overlap(overlap), .cnt_clr(cnt_clr),
      .z(z2), .match_cnt(cnt2), .armed(armed2)
   );

   typedef struct {
      logic       z;
      logic [7:0] cnt;
      logic [1:0] cnt2;
      logic       armed;
   } exp_t;

   exp_t       sbq[$];
   int         n_cmp = 0;
   int         n_mis = 0;

   int         mbits[$];
   logic [7:0] mpat;
   int         mlen;
   int         mcnt, mcnt2;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      mbits.delete();
      mpat  = 8'h0B;
      mlen  = 4;
      mcnt  = 0;
      mcnt2 = 0;
   endtask

   task automatic step(input logic xi, input logic vi, input logic ld,
                       input logic clr, input logic ov,
                       input logic [7:0] p, input logic [3:0] pl,
                       input string tag);
      exp_t e;
      int   n;
      bit   m;
      x = xi; in_valid = vi; pat_load = ld;
      cnt_clr = clr; overlap = ov; pat = p; pat_len = pl;
      m = 0;
      if (ld) begin
         mpat = p;
         mlen = (pl > 8) ? 8 : int'(pl);
         mbits.delete();
      end else if (vi) begin
         mbits.push_back(int'(xi));
         if (mbits.size() > 8) void'(mbits.pop_front());
         n = mbits.size();
         if (mlen > 0 && n >= mlen) begin
            m = 1;
            for (int i = 0; i < mlen; i++)
               if (mbits[n-1-i] != int'(mpat[i])) m = 0;
         end
         if (m && !ov) mbits.delete();
      end
      if (clr) begin
         mcnt  = int'(m);
         mcnt2 = int'(m);
      end else if (m) begin
         if (mcnt < 255) mcnt++;
         if (mcnt2 < 3) mcnt2++;
      end
      e.z = m; e.cnt = mcnt[7:0]; e.cnt2 = mcnt2[1:0];
      e.armed = (mlen != 0);
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk({tag, ".z"}, 32'(z), 32'(e.z));
      chk({tag, ".z2"}, 32'(z2), 32'(e.z));
      chk({tag, ".cnt"}, 32'(cnt), 32'(e.cnt));
      chk({tag, ".cnt2"}, 32'(cnt2), 32'(e.cnt2));
      chk({tag, ".armed"}, 32'(armed), 32'(e.armed));
      chk({tag, ".armed2"}, 32'(armed2), 32'(e.armed));
   endtask

   task automatic feed(input logic [15:0] seq, input int len,
                       input logic ov, input string tag);
      for (int i = len - 1; i >= 0; i--)
         step(seq[i], 1'b1, 1'b0, 1'b0, ov, 8'h00, 4'd0, tag);
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] pl,
                       input string tag);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, p, pl, tag);
   endtask

   initial begin
      reset = 1'b1; x = 1'b0; in_valid = 1'b0; pat_load = 1'b0;
      overlap = 1'b1; cnt_clr = 1'b0; pat = 8'h00; pat_len = 4'd0;
      mreset();
      #3;
      chk("rst.z", 32'(z), 32'd0);
      chk("rst.cnt", 32'(cnt), 32'd0);
      chk("rst.armed", 32'(armed), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // overlapping 1011 on 1011011
      feed(16'b1011011, 7, 1'b1, "ovl");
      chk("ovl.total", 32'(cnt), 32'd2);

      // non-overlapping, same stream
      load(8'h0B, 4'd4, "ld0");
      feed(16'b1011011, 7, 1'b0, "novl");
      chk("novl.total", 32'(cnt), 32'd1);

      // pattern 110 with in_valid toggling
      load(8'h06, 4'd3, "ld1");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, "tog0");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, "tog1");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, "tog2");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, "tog3");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, "tog4");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, "tog5");
      chk("tog.total", 32'(cnt), 32'd1);

      // zero length disables detection
      load(8'h0B, 4'd0, "ld2");
      feed(16'b1011_1011_1011, 12, 1'b1, "dis");
      chk("dis.total", 32'(cnt), 32'd0);

      // oversize length clamps to 8
      load(8'hB3, 4'd12, "ld3");
      feed(16'b1011_0011, 8, 1'b1, "clamp");
      chk("clamp.total", 32'(cnt), 32'd1);

      // bits above active length ignored
      load(8'hFB, 4'd3, "ld4");
      feed(16'b111, 3, 1'b1, "mask0");
      feed(16'b011, 3, 1'b1, "mask1");

      // counter saturation on the 2-bit instance, clear vs match
      load(8'h03, 4'd2, "ld5");
      feed(16'b111111, 6, 1'b1, "sat");
      chk("sat.cnt2", 32'(cnt2), 32'd3);
      chk("sat.cnt", 32'(cnt), 32'd5);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'd0, "clrm");
      chk("clrm.cnt2", 32'(cnt2), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 4'd0, "clr");
      feed(16'b11, 2, 1'b1, "sat2");

      // reset in the middle of a partial match
      load(8'h0B, 4'd4, "ld6");
      feed(16'b1011, 4, 1'b1, "pre");
      feed(16'b101, 3, 1'b1, "part");
      #2;
      reset = 1'b1;
      #1;
      chk("mrst.z", 32'(z), 32'd0);
      chk("mrst.cnt", 32'(cnt), 32'd0);
      chk("mrst.armed", 32'(armed), 32'd1);
      mreset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      feed(16'b1, 1, 1'b1, "post0");
      feed(16'b011, 3, 1'b1, "post1");
      chk("post.total", 32'(cnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
